// File: rtl/hex_codes_pkg.sv
// ============================================================================
// Module : hex_codes_pkg
// Brief  : Character codes shared by the HEX scroll controller and decoders.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hex_codes_pkg;

  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CH_H = 2'd0;
  localparam code_t CH_E = 2'd1;
  localparam code_t CH_L = 2'd2;
  localparam code_t CH_O = 2'd3;

endpackage

`default_nettype wire

// File: rtl/hex_scroll_ctrl_if.sv
// ============================================================================
// Module : hex_scroll_ctrl_if
// Brief  : Control, message-write and digit signals of the scroll controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hex_scroll_ctrl_if #(
  parameter int MSG_LEN = 4
);
  import hex_codes_pkg::*;

  localparam int PTR_W = $clog2(MSG_LEN);

  logic             Run;
  logic             Dir;
  logic             Step;
  logic             Wr;
  logic [PTR_W-1:0] WrAddr;
  code_t            WrData;
  logic [PTR_W-1:0] Pos;
  logic             Tick;
  code_t            Digit3;
  code_t            Digit2;
  code_t            Digit1;
  code_t            Digit0;

  modport master (
    output Run, Dir, Step, Wr, WrAddr, WrData,
    input  Pos, Tick, Digit3, Digit2, Digit1, Digit0
  );

  modport slave (
    input  Run, Dir, Step, Wr, WrAddr, WrData,
    output Pos, Tick, Digit3, Digit2, Digit1, Digit0
  );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module : tick_prescaler
// Brief  : Enable-gated modulo-TICK_DIV counter with a registered one-cycle Tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  wire  CLOCK_50,
  input  wire  Reset,
  input  wire  En,
  output logic Tick
);

  localparam int               CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // While disabled the count is frozen so that counting resumes where it stopped.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      Tick <= 1'b0;
    end else begin
      Tick <= En & (cnt == LAST);
      if (En) begin
        cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
// ============================================================================
// Module : hex_scroll_ctrl
// Brief  : Rotates a small message buffer across four HEX digit code outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_scroll_ctrl
  import hex_codes_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MSG_LEN  = 4
) (
  input  wire              CLOCK_50,
  input  wire              Reset,
  hex_scroll_ctrl_if.slave bus
);

  localparam int               PTR_W    = $clog2(MSG_LEN);
  localparam int               IW       = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_POS = PTR_W'(MSG_LEN - 1);

  logic             tick;
  logic             step_q;
  logic             advance;
  logic [PTR_W-1:0] pos;
  code_t            msg    [MSG_LEN];
  code_t            digit  [4];
  logic [PTR_W-1:0] rd_idx [4];

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .En       (bus.Run),
    .Tick     (tick)
  );

  // Manual stepping only counts while paused; a held Step yields one advance.
  assign advance = tick | (~bus.Run & bus.Step & ~step_q);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      pos    <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= bus.Step;
      if (advance) begin
        if (bus.Dir) begin
          pos <= (pos == '0) ? LAST_POS : pos - PTR_W'(1);
        end else begin
          pos <= (pos == LAST_POS) ? '0 : pos + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= code_t'(i % (1 << CODE_W));
      end
    end else if (bus.Wr && (int'(bus.WrAddr) < MSG_LEN)) begin
      msg[bus.WrAddr] <= bus.WrData;
    end
  end

  // Digit K shows slot (Pos + 3 - K) mod MSG_LEN; one subtraction suffices.
  for (genvar k = 0; k < 4; k++) begin : g_rd_idx
    logic [PTR_W:0] sum;
    assign sum       = {1'b0, pos} + IW'(3 - k);
    assign rd_idx[k] = (sum >= IW'(MSG_LEN)) ? PTR_W'(sum - IW'(MSG_LEN))
                                              : sum[PTR_W-1:0];
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      digit[3] <= CH_H;
      digit[2] <= CH_E;
      digit[1] <= CH_L;
      digit[0] <= CH_O;
    end else begin
      for (int k = 0; k < 4; k++) begin
        digit[k] <= msg[rd_idx[k]];
      end
    end
  end

  assign bus.Pos    = pos;
  assign bus.Tick   = tick;
  assign bus.Digit3 = digit[3];
  assign bus.Digit2 = digit[2];
  assign bus.Digit1 = digit[1];
  assign bus.Digit0 = digit[0];

endmodule

`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
// ============================================================================
// Module : tb_hex_scroll_ctrl
// Brief  : Directed and random checks of hex_scroll_ctrl at MSG_LEN 4 and 5.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hex_scroll_ctrl;
  import hex_codes_pkg::*;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, dir, step, wr;
  logic [2:0] waddr;
  code_t      wdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state, index 0 -> MSG_LEN 4, index 1 -> MSG_LEN 5
  int m_cnt [2];
  int m_pos [2];
  int m_msg [2][16];
  int m_dig [2][4];
  bit m_tick  [2];
  bit m_stepq [2];

  hex_scroll_ctrl_if #(.MSG_LEN(4)) bus_a ();
  hex_scroll_ctrl_if #(.MSG_LEN(5)) bus_b ();

  assign bus_a.Run    = run;   assign bus_b.Run    = run;
  assign bus_a.Dir    = dir;   assign bus_b.Dir    = dir;
  assign bus_a.Step   = step;  assign bus_b.Step   = step;
  assign bus_a.Wr     = wr;    assign bus_b.Wr     = wr;
  assign bus_a.WrData = wdata; assign bus_b.WrData = wdata;
  assign bus_a.WrAddr = waddr[1:0];
  assign bus_b.WrAddr = waddr;

  hex_scroll_ctrl #(.TICK_DIV(DIV), .MSG_LEN(4)) dut_a (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus_a)
  );

  hex_scroll_ctrl #(.TICK_DIV(DIV), .MSG_LEN(5)) dut_b (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_dig(int i);
    return 32'((m_dig[i][3] << 6) | (m_dig[i][2] << 4) | (m_dig[i][1] << 2) | m_dig[i][0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_pos[i]   = 0;
      m_tick[i]  = 0;
      m_stepq[i] = 0;
      for (int s = 0; s < 16; s++) m_msg[i][s] = s % 4;
      for (int j = 0; j < 4; j++)  m_dig[i][j] = (3 - j) % 4;
    end
  endtask

  // One clock edge of the specified behaviour, from pre-edge state and inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int len;
      int a;
      int nd [4];
      bit adv;
      len = (i == 0) ? 4 : 5;
      for (int j = 0; j < 4; j++) nd[j] = m_msg[i][(m_pos[i] + 3 - j) % len];
      adv = m_tick[i] || (!run && step && !m_stepq[i]);
      m_tick[i] = run && (m_cnt[i] == DIV - 1);
      if (run) m_cnt[i] = (m_cnt[i] + 1) % DIV;
      if (adv) m_pos[i] = dir ? (m_pos[i] + len - 1) % len : (m_pos[i] + 1) % len;
      a = (i == 0) ? int'(waddr[1:0]) : int'(waddr);
      if (wr && a < len) m_msg[i][a] = int'(wdata);
      m_stepq[i] = step;
      for (int j = 0; j < 4; j++) m_dig[i][j] = nd[j];
    end
  endtask

  task automatic check_all();
    chk("A.Pos",    32'(bus_a.Pos), 32'(m_pos[0]));
    chk("A.Tick",   32'(bus_a.Tick), 32'(m_tick[0]));
    chk("A.Digits", 32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), pack_dig(0));
    chk("B.Pos",    32'(bus_b.Pos), 32'(m_pos[1]));
    chk("B.Tick",   32'(bus_b.Tick), 32'(m_tick[1]));
    chk("B.Digits", 32'({bus_b.Digit3, bus_b.Digit2, bus_b.Digit1, bus_b.Digit0}), pack_dig(1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Called just after a falling edge; reset lands mid-cycle.
  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst.A.Digits", 32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), 32'h1B);
    chk("rst.A.Tick", 32'(bus_a.Tick), 32'h0);
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0;
    wr = 1'b0; waddr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("init.A.Pos", 32'(bus_a.Pos), 32'h0);
    chk("init.A.Digits", 32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), 32'h1B);
    rst = 1'b0;

    // Scroll left
    run = 1'b1; dir = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      cycle();
      if (c == 4)  chk("left.first_tick", 32'(bus_a.Tick), 32'h1);
      if (c == 6)  chk("left.digits_1230",
                       32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), 32'h6C);
      if (c == 17) chk("left.pos_wrap", 32'(bus_a.Pos), 32'h0);
    end

    // Scroll right
    apply_reset();
    run = 1'b1; dir = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      if (c == 5) chk("right.pos_wrap", 32'(bus_a.Pos), 32'h3);
      if (c == 6) chk("right.digits_3012",
                      32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), 32'hC6);
    end

    // Pause at count 2, single step, resume
    apply_reset();
    run = 1'b1; dir = 1'b0;
    repeat (2) cycle();
    run = 1'b0;
    repeat (20) cycle();
    step = 1'b1;
    repeat (5) cycle();
    step = 1'b0;
    repeat (2) cycle();
    chk("pause.single_step", 32'(bus_a.Pos), 32'h1);
    run = 1'b1;
    cycle();
    chk("resume.no_tick_yet", 32'(bus_a.Tick), 32'h0);
    cycle();
    chk("resume.tick", 32'(bus_a.Tick), 32'h1);

    // Message writes, in range and out of range
    apply_reset();
    run = 1'b0;
    wr = 1'b1; waddr = 3'd2; wdata = CH_H;
    cycle();
    wr = 1'b0;
    cycle();
    chk("write.A.Digit1", 32'(bus_a.Digit1), 32'h0);
    wr = 1'b1; waddr = 3'd5; wdata = CH_O;
    cycle();
    wr = 1'b0;
    cycle();
    chk("write.B.out_of_range",
        32'({bus_b.Digit3, bus_b.Digit2, bus_b.Digit1, bus_b.Digit0}), 32'h13);

    // Write coincident with the advance
    apply_reset();
    run = 1'b1; dir = 1'b0;
    repeat (4) cycle();
    wr = 1'b1; waddr = 3'd1; wdata = CH_H;
    cycle();
    wr = 1'b0;
    cycle();
    chk("coincident.digits",
        32'({bus_a.Digit3, bus_a.Digit2, bus_a.Digit1, bus_a.Digit0}), 32'h2C);

    // Async reset mid-count, then restart from zero
    apply_reset();
    run = 1'b1; dir = 1'b0;
    repeat (11) cycle();
    chk("midcount.pos", 32'(bus_a.Pos), 32'h2);
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      cycle();
      if (c == 3) chk("restart.no_tick", 32'(bus_a.Tick), 32'h0);
      if (c == 4) chk("restart.tick", 32'(bus_a.Tick), 32'h1);
    end

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      run   = ($urandom_range(0, 3) != 0);
      dir   = 1'($urandom_range(0, 1));
      step  = 1'($urandom_range(0, 1));
      wr    = ($urandom_range(0, 3) == 0);
      waddr = 3'($urandom_range(0, 7));
      wdata = code_t'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) apply_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
